// File: rtl/drive_mode_controller.sv
// Drive mode controller: engine start/stop sequencing and gear-selector arbitration.
// Enforces brake-to-start, park-to-stop, zero-speed for P/R and fuel-out stall.
module drive_mode_controller #(
  parameter int unsigned CRANK_TICKS = 2,
  parameter logic [3:0]  GEAR_P      = 4'd3,
  parameter logic [3:0]  GEAR_R      = 4'd6,
  parameter logic [3:0]  GEAR_N      = 4'd9,
  parameter logic [3:0]  GEAR_D      = 4'd12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1sec,
  input  logic       btn_start,
  input  logic       req_gear_valid,
  input  logic [3:0] req_gear,
  input  logic       is_brake_normal,
  input  logic       is_brake_hard,
  input  logic [7:0] speed,
  input  logic [7:0] fuel,
  output logic       engine_on,
  output logic [3:0] current_gear,
  output logic       crank_active,
  output logic       stall,
  output logic       start_reject,
  output logic       shift_done,
  output logic       shift_reject
);

  typedef enum logic [1:0] {StOff, StCrank, StRun, StStall} state_e;

  localparam logic [3:0] LastTick = 4'(CRANK_TICKS - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       start_reject_d;
  logic       shift_done_d, shift_reject_d;

  logic brake, fuel_out, in_park, stopped, start_ok, stop_ok;

  assign brake    = is_brake_normal | is_brake_hard;
  assign fuel_out = (fuel == 8'd0);
  assign in_park  = (current_gear == GEAR_P);
  assign stopped  = (speed == 8'd0);
  assign start_ok = brake & in_park & ~fuel_out;
  assign stop_ok  = stopped & in_park;

  // Engine next-state, crank counter and start-reject decision.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    start_reject_d = 1'b0;
    case (state_q)
      StOff: begin
        if (btn_start) begin
          if (start_ok) begin
            state_d = StCrank;
            cnt_d   = 4'd0;
          end else begin
            start_reject_d = 1'b1;
          end
        end
      end
      StCrank: begin
        // Abort beats a coincident tick.
        if (!brake || fuel_out) begin
          state_d = StOff;
        end else if (tick_1sec) begin
          if (cnt_q == LastTick) state_d = StRun;
          else                   cnt_d   = cnt_q + 4'd1;
        end
      end
      StRun: begin
        if (fuel_out) begin
          state_d = StStall;
        end else if (btn_start) begin
          if (stop_ok) state_d        = StOff;
          else         start_reject_d = 1'b1;
        end
      end
      StStall: begin
        if (btn_start) begin
          if (start_ok) begin
            state_d = StCrank;
            cnt_d   = 4'd0;
          end else begin
            start_reject_d = 1'b1;
          end
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Gear arbiter, judged against the pre-edge state, gear and speed.
  always_comb begin
    logic code_ok, target_ok, brake_ok, speed_ok;
    code_ok   = (req_gear == GEAR_P) || (req_gear == GEAR_R) ||
                (req_gear == GEAR_N) || (req_gear == GEAR_D);
    // With the engine not running only P and N are reachable.
    target_ok = (state_q == StRun) || (req_gear == GEAR_P) || (req_gear == GEAR_N);
    brake_ok  = !in_park || brake;
    if ((req_gear == GEAR_P) || (req_gear == GEAR_R)) begin
      speed_ok = stopped;
    end else if ((req_gear == GEAR_D) && (current_gear == GEAR_R)) begin
      speed_ok = stopped;
    end else begin
      speed_ok = 1'b1;
    end
    shift_done_d   = 1'b0;
    shift_reject_d = 1'b0;
    if (req_gear_valid && (req_gear != current_gear)) begin
      if (code_ok && target_ok && brake_ok && speed_ok) shift_done_d   = 1'b1;
      else                                              shift_reject_d = 1'b1;
    end
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StOff;
      cnt_q        <= 4'd0;
      current_gear <= GEAR_P;
      engine_on    <= 1'b0;
      crank_active <= 1'b0;
      stall        <= 1'b0;
      start_reject <= 1'b0;
      shift_done   <= 1'b0;
      shift_reject <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      engine_on    <= (state_d == StRun);
      crank_active <= (state_d == StCrank);
      stall        <= (state_d == StStall);
      start_reject <= start_reject_d;
      shift_done   <= shift_done_d;
      shift_reject <= shift_reject_d;
      if (shift_done_d) current_gear <= req_gear;
    end
  end

endmodule

// File: tb/tb_drive_mode_controller.sv
// Self-checking bench for drive_mode_controller: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural model of the drive rules.
module tb_drive_mode_controller;

  localparam int unsigned CrankTicks = 2;
  localparam logic [3:0] GP = 4'd3, GR = 4'd6, GN = 4'd9, GD = 4'd12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1sec = 1'b0, btn_start = 1'b0, req_gear_valid = 1'b0;
  logic [3:0] req_gear = 4'd0;
  logic       is_brake_normal = 1'b0, is_brake_hard = 1'b0;
  logic [7:0] speed = 8'd0, fuel = 8'd100;
  logic       engine_on, crank_active, stall, start_reject, shift_done, shift_reject;
  logic [3:0] current_gear;

  drive_mode_controller #(
    .CRANK_TICKS(CrankTicks), .GEAR_P(GP), .GEAR_R(GR), .GEAR_N(GN), .GEAR_D(GD)
  ) dut (
    .clk(clk), .rst(rst), .tick_1sec(tick_1sec), .btn_start(btn_start),
    .req_gear_valid(req_gear_valid), .req_gear(req_gear),
    .is_brake_normal(is_brake_normal), .is_brake_hard(is_brake_hard),
    .speed(speed), .fuel(fuel), .engine_on(engine_on), .current_gear(current_gear),
    .crank_active(crank_active), .stall(stall), .start_reject(start_reject),
    .shift_done(shift_done), .shift_reject(shift_reject)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: engine mode, ticks counted while cranking, gear and pulses.
  typedef enum int {MOff, MCrank, MRun, MStall} mode_t;
  mode_t    m_mode;
  int       m_ticks;
  logic [3:0] m_gear;
  logic     m_srej, m_done, m_rej;

  function automatic bit shift_allowed(input mode_t mode, input logic [3:0] from,
                                       input logic [3:0] to, input bit brk, input int spd);
    if (!(to inside {GP, GR, GN, GD})) return 0;
    if (mode != MRun && !(to inside {GP, GN})) return 0;
    if (from == GP && !brk) return 0;
    if ((to == GP || to == GR) && spd != 0) return 0;
    if (to == GD && from == GR && spd != 0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_mode = MOff; m_ticks = 0; m_gear = GP; m_srej = 0; m_done = 0; m_rej = 0;
  endtask

  task automatic model_step();
    bit    brk;
    bit    can_start;
    mode_t pre;
    brk       = is_brake_normal || is_brake_hard;
    can_start = brk && m_gear == GP && fuel != 0;
    pre       = m_mode;
    m_srej = 0; m_done = 0; m_rej = 0;
    if (req_gear_valid && req_gear != m_gear) begin
      if (shift_allowed(pre, m_gear, req_gear, brk, int'(speed))) m_done = 1;
      else m_rej = 1;
    end
    case (pre)
      MOff, MStall: if (btn_start) begin
        if (can_start) begin m_mode = MCrank; m_ticks = 0; end
        else m_srej = 1;
      end
      MCrank: begin
        if (!brk || fuel == 0) m_mode = MOff;
        else if (tick_1sec) begin
          m_ticks++;
          if (m_ticks >= CrankTicks) m_mode = MRun;
        end
      end
      MRun: begin
        if (fuel == 0) m_mode = MStall;
        else if (btn_start) begin
          if (speed == 0 && m_gear == GP) m_mode = MOff;
          else m_srej = 1;
        end
      end
      default: m_mode = MOff;
    endcase
    if (m_done) m_gear = req_gear;
  endtask

  task automatic compare_all(input string ctx);
    check_eq({ctx, ".engine_on"}, 32'(engine_on), 32'(m_mode == MRun));
    check_eq({ctx, ".crank_active"}, 32'(crank_active), 32'(m_mode == MCrank));
    check_eq({ctx, ".stall"}, 32'(stall), 32'(m_mode == MStall));
    check_eq({ctx, ".gear"}, 32'(current_gear), 32'(m_gear));
    check_eq({ctx, ".start_reject"}, 32'(start_reject), 32'(m_srej));
    check_eq({ctx, ".shift_done"}, 32'(shift_done), 32'(m_done));
    check_eq({ctx, ".shift_reject"}, 32'(shift_reject), 32'(m_rej));
  endtask

  // One clock: model decides on pre-edge inputs, DUT sampled #1 after the edge,
  // pulse inputs cleared at the following negedge.
  task automatic cycle(input string ctx);
    model_step();
    @(posedge clk);
    #1;
    compare_all(ctx);
    @(negedge clk);
    tick_1sec = 0; btn_start = 0; req_gear_valid = 0;
  endtask

  task automatic do_reset(input string ctx);
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    compare_all(ctx);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic req(input logic [3:0] g);
    req_gear_valid = 1; req_gear = g;
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // Start refused without brake.
    btn_start = 1; cycle("nobrake_start");
    check_eq("nobrake_start.srej_const", 32'(start_reject), 32'd1);

    // Normal start: two ticks of cranking, then RUN.
    is_brake_normal = 1; fuel = 100;
    btn_start = 1; cycle("start");
    tick_1sec = 1; cycle("tick1");
    check_eq("tick1.crank_const", 32'(crank_active), 32'd1);
    tick_1sec = 1; cycle("tick2");
    check_eq("tick2.engine_const", 32'(engine_on), 32'd1);

    // Gear arbitration while running.
    req(GD); cycle("run_to_d");
    check_eq("run_to_d.gear_const", 32'(current_gear), 32'd12);
    speed = 30; req(GR); cycle("d_to_r_moving");
    check_eq("d_to_r_moving.rej_const", 32'(shift_reject), 32'd1);
    req(GN); cycle("d_to_n_moving");
    speed = 0; req(GP); cycle("n_to_p_stopped");
    check_eq("n_to_p_stopped.gear_const", 32'(current_gear), 32'd3);
    req(GD); cycle("p_to_d_again");
    speed = 40; btn_start = 1; cycle("stop_moving");
    fuel = 0; cycle("fuel_out");
    check_eq("fuel_out.gear_const", 32'(current_gear), 32'd12);
    repeat (2) cycle("stalled");

    // Crank abort on brake release, then reset mid-crank.
    do_reset("reset2");
    speed = 0; fuel = 100; is_brake_normal = 1;
    btn_start = 1; cycle("start2");
    tick_1sec = 1; cycle("crank_t1");
    is_brake_normal = 0; tick_1sec = 1; cycle("abort");
    repeat (2) cycle("after_abort");
    is_brake_hard = 1; btn_start = 1; cycle("start3");
    do_reset("reset_mid_crank");
    check_eq("reset_mid_crank.gear_const", 32'(current_gear), 32'd3);

    // Invalid code, D while off, same gear.
    req(4'd5); cycle("bad_code");
    req(GD); cycle("d_while_off");
    req(GP); cycle("same_gear");

    // Randomized run.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset("rand_reset");
      end else begin
        is_brake_normal = ($urandom_range(0, 3) != 0);
        is_brake_hard   = ($urandom_range(0, 7) == 0);
        speed     = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        fuel      = ($urandom_range(0, 39) == 0) ? 8'd0 : 8'($urandom_range(1, 100));
        tick_1sec = ($urandom_range(0, 2) == 0);
        btn_start = ($urandom_range(0, 5) == 0);
        req_gear_valid = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 4))
          0: req_gear = GP;
          1: req_gear = GR;
          2: req_gear = GN;
          3: req_gear = GD;
          default: req_gear = 4'($urandom);
        endcase
        cycle("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/drive_mode_controller.md
Name: drive_mode_controller

Overview:
- Sequences engine start/stop and arbitrates gear-selector requests for the vehicle physics block.
- Produces the engine_on and current_gear signals that the physics block consumes.
- Enforces the safety interlocks: brake-to-start, park-to-stop, zero-speed for P/R, and fuel-out stall.
- Sits between the keypad/button decoders and the physics/OBD block, and reads back speed and fuel.

Parameters:
- CRANK_TICKS, 2, number of tick_1sec pulses spent cranking before the engine runs (range 1..15).
- GEAR_P, 4'd3, code for Park.
- GEAR_R, 4'd6, code for Reverse.
- GEAR_N, 4'd9, code for Neutral.
- GEAR_D, 4'd12, code for Drive.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick_1sec  in  1  one-cycle pulse, once per second
- btn_start  in  1  one-cycle pulse from the start/stop button
- req_gear_valid  in  1  one-cycle pulse: gear request present
- req_gear  in  4  requested gear code
- is_brake_normal  in  1  normal brake pressed
- is_brake_hard  in  1  hard brake pressed
- speed  in  8  current speed in km/h
- fuel  in  8  fuel level in %
- engine_on  out  1  engine running
- current_gear  out  4  active gear code
- crank_active  out  1  high while in CRANK
- stall  out  1  high while in STALL
- start_reject  out  1  one-cycle pulse: btn_start refused
- shift_done  out  1  one-cycle pulse: gear changed
- shift_reject  out  1  one-cycle pulse: gear request refused

Behaviour:
- Reset values: state=OFF, engine_on=0, current_gear=GEAR_P, crank_active=0, stall=0, all pulses 0, crank counter 0.
- All outputs are registered. A decision sampled in cycle n appears on the outputs in cycle n+1.
- brake = is_brake_normal | is_brake_hard.
- Engine FSM, states OFF, CRANK, RUN, STALL:
  - OFF: if btn_start & brake & current_gear==GEAR_P & fuel!=0, go to CRANK and clear the counter. If btn_start with any condition failing, pulse start_reject and stay in OFF.
  - CRANK: crank_active=1, engine_on=0.
    - Brake released: go to OFF at once (abort, no reject pulse).
    - fuel==0: go to OFF.
    - Otherwise, each tick_1sec increments the counter. When a tick arrives with counter==CRANK_TICKS-1, go to RUN.
    - btn_start is ignored (no pulse).
  - RUN: engine_on=1.
    - fuel==0: go to STALL. This has priority over btn_start.
    - btn_start & speed==0 & current_gear==GEAR_P: go to OFF.
    - btn_start otherwise: pulse start_reject.
  - STALL: stall=1, engine_on=0.
    - btn_start & brake & current_gear==GEAR_P & fuel!=0: go to CRANK.
    - btn_start otherwise: pulse start_reject.
- Gear arbiter, evaluated only on req_gear_valid, using the pre-edge state, gear and speed:
  - req_gear not one of the four codes: reject.
  - req_gear==current_gear: no change, no pulse.
  - State is not RUN: only GEAR_P or GEAR_N is accepted. GEAR_N additionally requires brake if leaving P. Anything else is rejected.
  - Leaving GEAR_P to any gear requires brake.
  - Target GEAR_P or GEAR_R requires speed==0.
  - Target GEAR_D from GEAR_R requires speed==0.
  - Target GEAR_N is allowed at any speed, subject to the brake rule when leaving P.
  - Target GEAR_D from GEAR_N or GEAR_P is allowed at any speed, subject to the brake rule.
  - Accept: current_gear<=req_gear and shift_done pulses. Reject: gear holds and shift_reject pulses. The two pulses are mutually exclusive.
- Simultaneous events:
  - btn_start and req_gear_valid in the same cycle are both judged against the pre-edge state and gear. A start in OFF plus a D request gives CRANK plus shift_reject. A stop in RUN with gear P plus an N request gives OFF plus shift_done to N.
  - tick_1sec coinciding with a brake release in CRANK: the abort wins.
- Entering STALL or OFF never changes current_gear.
- Asynchronous reset mid-crank or mid-run returns to the reset values immediately.

Test Plan:
- Reset, brake=1, gear P, fuel=100, btn_start, then 2 tick_1sec → crank_active=1 for both ticks, engine_on=1 one cycle after the second tick, start_reject never pulses.
- OFF, gear P, brake=0, btn_start → start_reject pulses once, state stays OFF, engine_on=0.
- RUN, brake=1, request D (12) → shift_done, current_gear=12. With speed=30, request R (6) → shift_reject, gear stays 12. Request N (9) → accepted. At speed=0, request P → accepted.
- RUN, gear D, speed=40, btn_start → start_reject pulses, engine_on stays 1. Drive fuel to 0 → stall=1, engine_on=0, gear stays 12.
- CRANK, brake released after 1 tick → OFF the next cycle, engine_on never asserts. Assert rst mid-crank → crank_active=0 and gear=3 immediately.
- Request code 5, and request D while OFF → shift_reject each time. Request 3 while already in P → no pulse on either output.
